// File: rtl/l2_line_responder.sv
// L2 responder for L1 line-fill misses: request FIFO, direct-mapped tag store with
// allocate-on-miss, fixed hit/miss response latency and lookup statistics.
//
// state | meaning
// IDLE  | waiting for a queued request; pops the head and performs the tag lookup
// WAIT  | counting down the hit or miss latency
// RESP  | response presented until resp_ready
module l2_line_responder #(
    parameter int DEPTH    = 4,
    parameter int IDX_BITS = 10,
    parameter int HIT_LAT  = 2,
    parameter int MISS_LAT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [25:0] req_addr,
    output logic        req_ready,
    input  logic        inv_valid,
    input  logic [25:0] inv_addr,
    output logic        resp_valid,
    output logic [25:0] resp_addr,
    output logic        resp_hit,
    input  logic        resp_ready,
    output logic [31:0] l2_reads,
    output logic [31:0] l2_hit,
    output logic [31:0] l2_miss
);
    localparam int LINE_W  = 20;
    localparam int TAG_W   = LINE_W - IDX_BITS;
    localparam int LINES   = 1 << IDX_BITS;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int MAX_LAT = (HIT_LAT > MISS_LAT) ? HIT_LAT : MISS_LAT;
    localparam int LAT_W   = $clog2(MAX_LAT + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]        state;
    logic [LAT_W-1:0]  lat_cnt;

    logic [LINE_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;

    logic [TAG_W-1:0]  tag_mem [LINES];
    logic [LINES-1:0]  valid_bits;

    logic                push;
    logic                pop;
    logic [LINE_W-1:0]   head_line;
    logic [IDX_BITS-1:0] head_idx;
    logic [TAG_W-1:0]    head_tag;
    logic                lookup_hit;
    logic                alloc;
    logic [LINE_W-1:0]   inv_line;
    logic [IDX_BITS-1:0] inv_idx;
    logic [TAG_W-1:0]    inv_tag;
    logic                inv_match;
    logic                unused_offset;

    assign unused_offset = ^{req_addr[5:0], inv_addr[5:0]};

    assign req_ready  = (count != (PTR_W+1)'(DEPTH));
    assign push       = req_valid && req_ready;
    assign pop        = (state == IDLE) && (count != '0);
    assign resp_valid = (state == RESP);

    assign head_line  = fifo_mem[rd_ptr];
    assign head_idx   = head_line[IDX_BITS-1:0];
    assign head_tag   = head_line[LINE_W-1:IDX_BITS];
    assign lookup_hit = valid_bits[head_idx] && (tag_mem[head_idx] == head_tag);
    assign alloc      = pop && !lookup_hit;

    assign inv_line   = inv_addr[25:6];
    assign inv_idx    = inv_line[IDX_BITS-1:0];
    assign inv_tag    = inv_line[LINE_W-1:IDX_BITS];
    // Invalidate acts after a same-cycle allocate, so compare against the tag being written.
    assign inv_match  = (alloc && (head_idx == inv_idx)) ? (head_tag == inv_tag)
                                                          : (tag_mem[inv_idx] == inv_tag);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= req_addr[25:6];
        end
        if (alloc) begin
            tag_mem[head_idx] <= head_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            valid_bits <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
            if (alloc) begin
                valid_bits[head_idx] <= 1'b1;
            end
            if (inv_valid && inv_match) begin
                valid_bits[inv_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            resp_addr <= '0;
            resp_hit  <= 1'b0;
            l2_reads  <= '0;
            l2_hit    <= '0;
            l2_miss   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        resp_addr <= {head_line, 6'b0};
                        resp_hit  <= lookup_hit;
                        l2_reads  <= l2_reads + 32'd1;
                        if (lookup_hit) begin
                            l2_hit  <= l2_hit + 32'd1;
                            lat_cnt <= LAT_W'(HIT_LAT - 1);
                        end else begin
                            l2_miss <= l2_miss + 32'd1;
                            lat_cnt <= LAT_W'(MISS_LAT - 1);
                        end
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        state <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_l2_line_responder.sv
// Scoreboard bench for l2_line_responder: expected responses are queued at push time
// and compared in order as the responder answers.
module tb_l2_line_responder;
    localparam int HIT_LAT  = 2;
    localparam int MISS_LAT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [25:0] req_addr;
    logic        req_ready;
    logic        inv_valid;
    logic [25:0] inv_addr;
    logic        resp_valid;
    logic [25:0] resp_addr;
    logic        resp_hit;
    logic        resp_ready;
    logic [31:0] l2_reads;
    logic [31:0] l2_hit;
    logic [31:0] l2_miss;

    int checks = 0;
    int passes = 0;
    logic [26:0] sb_q[$];

    l2_line_responder #(.DEPTH(4), .IDX_BITS(10), .HIT_LAT(HIT_LAT), .MISS_LAT(MISS_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .inv_valid(inv_valid), .inv_addr(inv_addr),
        .resp_valid(resp_valid), .resp_addr(resp_addr), .resp_hit(resp_hit),
        .resp_ready(resp_ready),
        .l2_reads(l2_reads), .l2_hit(l2_hit), .l2_miss(l2_miss)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        inv_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        sb_q.delete();
    endtask

    // Drives one request until accepted; optionally records the expected response.
    task automatic push_req(input logic [25:0] a, input logic exp_hit, input bit record);
        int n = 0;
        req_valid = 1'b1;
        req_addr  = a;
        while (!req_ready && n < 100) begin
            step();
            n++;
        end
        if (!req_ready) begin
            $display("FAIL push_stall addr=%h req_ready=0 required 1", a);
            $fatal(1);
        end
        @(posedge clk);
        if (record) sb_q.push_back({a[25:6], 6'b0, exp_hit});
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output bit ok, output int cyc);
        cyc = 0;
        while (!resp_valid && cyc < 60) begin
            step();
            cyc++;
        end
        ok = resp_valid;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid got %b required 0", resp_valid); else passes++;
        checks++; if ({resp_addr, resp_hit} !== 27'd0) $display("FAIL rst_resp got addr=%h hit=%b required 0", resp_addr, resp_hit); else passes++;
        checks++; if ({l2_reads, l2_hit, l2_miss} !== 96'd0) $display("FAIL rst_counters got %0d/%0d/%0d required 0", l2_reads, l2_hit, l2_miss); else passes++;
        checks++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready got %b required 1", req_ready); else passes++;
    endtask

    task automatic test_miss_latency();
        bit ok; int cyc; logic [26:0] exp;
        resp_ready = 1'b1;
        push_req(26'h0001040, 1'b0, 1'b1);
        wait_resp(ok, cyc);
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : 27'h0;
        checks++; if (!ok || cyc != MISS_LAT + 1) $display("FAIL miss_latency got %0d cycles required %0d", cyc, MISS_LAT + 1); else passes++;
        checks++; if ({resp_addr, resp_hit} !== exp) $display("FAIL miss_resp got addr=%h hit=%b required addr=%h hit=%b", resp_addr, resp_hit, exp[26:1], exp[0]); else passes++;
        step();
        checks++; if (resp_valid !== 1'b0) $display("FAIL miss_handshake resp_valid got %b required 0", resp_valid); else passes++;
        checks++; if (l2_reads !== 32'd1 || l2_miss !== 32'd1 || l2_hit !== 32'd0) $display("FAIL miss_counters got r=%0d h=%0d m=%0d required 1/0/1", l2_reads, l2_hit, l2_miss); else passes++;
    endtask

    task automatic test_hit();
        bit ok; int cyc; logic [26:0] exp;
        logic [25:0] addrs [2];
        addrs[0] = 26'h0001040;
        addrs[1] = 26'h000107F;
        for (int i = 0; i < 2; i++) begin
            push_req(addrs[i], 1'b1, 1'b1);
            wait_resp(ok, cyc);
            exp = (sb_q.size() != 0) ? sb_q.pop_front() : 27'h0;
            checks++; if (!ok || cyc != HIT_LAT + 1) $display("FAIL hit_latency%0d got %0d cycles required %0d", i, cyc, HIT_LAT + 1); else passes++;
            checks++; if ({resp_addr, resp_hit} !== exp) $display("FAIL hit_resp%0d got addr=%h hit=%b required addr=%h hit=%b", i, resp_addr, resp_hit, exp[26:1], exp[0]); else passes++;
            step();
        end
        checks++; if (l2_hit !== 32'd2 || l2_reads !== 32'd3) $display("FAIL hit_counters got r=%0d h=%0d required 3/2", l2_reads, l2_hit); else passes++;
    endtask

    task automatic test_conflict();
        bit ok; int cyc; logic [26:0] exp;
        do_reset();
        resp_ready = 1'b1;
        push_req(26'h0001040, 1'b0, 1'b1);
        push_req(26'h0011040, 1'b0, 1'b1);
        push_req(26'h0001040, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            wait_resp(ok, cyc);
            exp = (sb_q.size() != 0) ? sb_q.pop_front() : 27'h0;
            checks++; if (!ok) $display("FAIL conflict_timeout%0d resp_valid got 0 required 1", i); else passes++;
            if (i == 1) begin
                checks++; if (cyc != MISS_LAT + 1) $display("FAIL back_to_back_gap got %0d cycles required %0d", cyc, MISS_LAT + 1); else passes++;
            end
            checks++; if ({resp_addr, resp_hit} !== exp) $display("FAIL conflict_resp%0d got addr=%h hit=%b required addr=%h hit=%b", i, resp_addr, resp_hit, exp[26:1], exp[0]); else passes++;
            step();
        end
        checks++; if (l2_miss !== 32'd3 || l2_hit !== 32'd0) $display("FAIL conflict_counters got h=%0d m=%0d required 0/3", l2_hit, l2_miss); else passes++;
    endtask

    task automatic test_backpressure();
        bit ok; int cyc; logic [26:0] exp;
        resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_req(26'h0002000 + 26'(i * 64), 1'b0, 1'b1);
        push_req(26'h0001040, 1'b1, 1'b1);
        checks++; if (req_ready !== 1'b0) $display("FAIL full_req_ready got %b required 0", req_ready); else passes++;
        for (int i = 0; i < 12; i++) step();
        checks++; if (resp_valid !== 1'b1 || req_ready !== 1'b0) $display("FAIL stall_hold got valid=%b ready=%b required 1/0", resp_valid, req_ready); else passes++;
        resp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_resp(ok, cyc);
            exp = (sb_q.size() != 0) ? sb_q.pop_front() : 27'h0;
            checks++; if (!ok || {resp_addr, resp_hit} !== exp) $display("FAIL order_resp%0d got valid=%b addr=%h hit=%b required addr=%h hit=%b", i, ok, resp_addr, resp_hit, exp[26:1], exp[0]); else passes++;
            step();
        end
        checks++; if (l2_reads !== 32'd8 || l2_hit !== 32'd1) $display("FAIL bp_counters got r=%0d h=%0d required 8/1", l2_reads, l2_hit); else passes++;
    endtask

    task automatic test_invalidate();
        bit ok; int cyc; logic [26:0] exp;
        logic [25:0] addrs [4];
        logic        hits  [4];
        addrs[0] = 26'h0011040; hits[0] = 1'b0;
        addrs[1] = 26'h0001040; hits[1] = 1'b0;
        addrs[2] = 26'h0001040; hits[2] = 1'b0;
        addrs[3] = 26'h0001040; hits[3] = 1'b1;
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                inv_valid = 1'b1;
                inv_addr  = 26'h0011040;
                step();
                inv_valid = 1'b0;
            end
            push_req(addrs[i], hits[i], 1'b1);
            if (i == 1) begin
                // lands on the edge where IDLE pops and allocates this same line
                inv_valid = 1'b1;
                inv_addr  = 26'h0001040;
                step();
                inv_valid = 1'b0;
            end
            wait_resp(ok, cyc);
            exp = (sb_q.size() != 0) ? sb_q.pop_front() : 27'h0;
            checks++; if (!ok || {resp_addr, resp_hit} !== exp) $display("FAIL inv_resp%0d got valid=%b addr=%h hit=%b required addr=%h hit=%b", i, ok, resp_addr, resp_hit, exp[26:1], exp[0]); else passes++;
            step();
        end
    endtask

    task automatic test_reset_midflight();
        bit ok; int cyc; logic [26:0] exp;
        bit seen = 1'b0;
        resp_ready = 1'b1;
        push_req(26'h0005000, 1'b0, 1'b0);
        push_req(26'h0006000, 1'b0, 1'b0);
        push_req(26'h0007000, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if ({l2_reads, l2_hit, l2_miss} !== 96'd0) $display("FAIL midrst_counters got %0d/%0d/%0d required 0", l2_reads, l2_hit, l2_miss); else passes++;
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) $display("FAIL midrst_handshake got ready=%b valid=%b required 1/0", req_ready, resp_valid); else passes++;
        for (int i = 0; i < 20; i++) begin
            if (resp_valid) seen = 1'b1;
            step();
        end
        checks++; if (seen) $display("FAIL midrst_dropped got response required none"); else passes++;
        push_req(26'h0001040, 1'b0, 1'b1);
        wait_resp(ok, cyc);
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : 27'h0;
        checks++; if (!ok || {resp_addr, resp_hit} !== exp) $display("FAIL midrst_resp got valid=%b addr=%h hit=%b required addr=%h hit=%b", ok, resp_addr, resp_hit, exp[26:1], exp[0]); else passes++;
        step();
        checks++; if (l2_miss !== 32'd1 || l2_reads !== 32'd1) $display("FAIL midrst_post_counters got r=%0d m=%0d required 1/1", l2_reads, l2_miss); else passes++;
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        inv_valid  = 1'b0;
        inv_addr   = '0;
        resp_ready = 1'b1;
        test_reset();
        test_miss_latency();
        test_hit();
        test_conflict();
        test_backpressure();
        test_invalidate();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
